// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divider: register-bus width, write-port
// constants and divider state encodings.
package hilo_div_pkg;

  localparam int unsigned RegWidth = 32;
  typedef logic [RegWidth-1:0] reg_bus_t;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic HILO_ADDR_LO = 1'b0;
  localparam logic HILO_ADDR_HI = 1'b1;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_ZERO,
    DIV_ON,
    DIV_WR_LO,
    DIV_WR_HI
  } div_state_e;

endpackage

// File: rtl/hilo_div.sv
// Iterative restoring divider, one quotient bit per cycle; commits the
// quotient to LO then the remainder to HI over the single HI/LO write port.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int unsigned WIDTH = RegWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             hilo_w_en_o,
  output logic             hilo_w_addr_o,
  output logic [WIDTH-1:0] hilo_w_data_o
);

  div_state_e state, state_nxt;

  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_shl;
  logic [2*WIDTH:0] acc_step;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [5:0]       cnt;
  logic             neg_q;
  logic             neg_r;
  logic             accept;

  assign accept = (state == DIV_IDLE) && start_i && !annul_i;

  assign dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // Trial subtract on the shifted upper half; a clear borrow bit keeps the difference.
  assign acc_shl  = acc << 1;
  assign trial    = acc_shl[2*WIDTH:WIDTH] - {1'b0, dvsr};
  assign acc_step = trial[WIDTH] ? acc_shl : {trial, acc_shl[WIDTH-1:1], 1'b1};

  assign quot = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      acc   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= '0;
        dvsr  <= divisor_mag;
        neg_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
        neg_r <= signed_i && dividend_i[WIDTH-1];
        // A zero result in the accumulator stays zero after sign correction.
        acc   <= (divisor_i == '0) ? '0 : {{(WIDTH+1){1'b0}}, dividend_mag};
      end else if (state == DIV_ON) begin
        acc <= acc_step;
        cnt <= cnt + 6'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE:  if (accept) state_nxt = (divisor_i == '0) ? DIV_ZERO : DIV_ON;
      DIV_ZERO:  state_nxt = annul_i ? DIV_IDLE : DIV_WR_LO;
      DIV_ON: begin
        if (annul_i)                     state_nxt = DIV_IDLE;
        else if (cnt == 6'(WIDTH - 1))   state_nxt = DIV_WR_LO;
      end
      DIV_WR_LO: state_nxt = DIV_WR_HI;
      DIV_WR_HI: state_nxt = DIV_IDLE;
      default:   state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    hilo_w_en_o   = WriteDisable;
    hilo_w_addr_o = HILO_ADDR_LO;
    hilo_w_data_o = '0;
    if (state == DIV_WR_LO) begin
      hilo_w_en_o   = WriteEnable;
      hilo_w_addr_o = HILO_ADDR_LO;
      hilo_w_data_o = neg_q ? -quot : quot;
    end else if (state == DIV_WR_HI) begin
      hilo_w_en_o   = WriteEnable;
      hilo_w_addr_o = HILO_ADDR_HI;
      hilo_w_data_o = neg_r ? -rem : rem;
    end
  end

  assign busy_o = ((state != DIV_IDLE) && (state != DIV_WR_HI)) || accept;
  assign done_o = (state == DIV_WR_HI);

endmodule

// File: doc/hilo_div.md
# hilo_div

Iterative 32-bit divider that is the write-side client of the HI/LO register pair. It accepts a divide request from the execute stage and runs a restoring division at one quotient bit per cycle. It then commits the quotient to LO and the remainder to HI over the single-port HI/LO write interface, LO first and HI second. While it owns the HI/LO port it holds off the pipeline through `busy_o`.

## Interface
- `WIDTH`, 32, operand and result width; must equal the register-bus width.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: divide request; sampled only in IDLE.
- `signed_i` in 1: 1 = two's-complement divide (DIV); 0 = unsigned divide (DIVU).
- `annul_i` in 1: kill the in-flight divide (branch flush or exception).
- `dividend_i` in WIDTH: numerator; captured with `start_i`.
- `divisor_i` in WIDTH: denominator; captured with `start_i`.
- `busy_o` out 1: pipeline stall request.
- `done_o` out 1: one-cycle pulse marking the final (HI) commit cycle.
- `hilo_w_en_o` out 1: HI/LO write enable.
- `hilo_w_addr_o` out 1: HI/LO write address; 0 = LO, 1 = HI.
- `hilo_w_data_o` out WIDTH: HI/LO write data.

## Operation
- States:
  - IDLE
  - DIV_ZERO: divisor is zero; entered when `start_i` is seen and `divisor_i == 0`.
  - DIV_ON: iterative divide.
  - WR_LO: writes the quotient to LO.
  - WR_HI: writes the remainder to HI.
- Transitions:
  - IDLE to DIV_ZERO when `start_i` is high and `divisor_i == 0`.
  - IDLE to DIV_ON when `start_i` is high and the divisor is non-zero.
  - DIV_ZERO to WR_LO after 1 cycle.
  - DIV_ON to WR_LO after exactly WIDTH iterations, counted by a 6-bit counter.
  - WR_LO to WR_HI, then WR_HI to IDLE.
- Signed mode:
  - Operands are replaced by their magnitudes at capture.
  - The quotient is negated if the operand signs differ.
  - The remainder is negated if the dividend is negative, so the remainder takes the sign of the dividend.
  - `0x80000000 / 0xFFFFFFFF` gives LO = `0x80000000`, HI = 0. This wraps silently; no trap is raised.
- Divide by zero: LO = 0 and HI = 0 in both signed and unsigned mode.
- Datapath:
  - A 2·WIDTH+1 shift register holds {remainder, quotient}.
  - Each cycle it shifts left one bit, then does a trial subtract of the divisor from the upper half.
  - If the result is non-negative, the upper half is replaced and quotient bit 1 is shifted in; otherwise bit 0 is shifted in.
- Annul:
  - `annul_i` high in DIV_ON or DIV_ZERO returns the block to IDLE on the next edge, with no HI/LO write.
  - `annul_i` in WR_LO or WR_HI is ignored; the commit completes atomically.
  - `annul_i` in IDLE together with `start_i`: the request is dropped and the block stays in IDLE.
- `start_i` outside IDLE is ignored. The pipeline is stalled in that window, so a restart cannot occur.
- Write port:
  - `hilo_w_en_o` is 1 only in WR_LO and WR_HI.
  - `hilo_w_addr_o` is 0 in WR_LO and 1 in WR_HI.
  - `hilo_w_data_o` carries the sign-corrected result.
  - All three are 0 in every other state.

## Timing
- Reset values: state IDLE; `busy_o`, `done_o`, `hilo_w_en_o`, `hilo_w_addr_o` and `hilo_w_data_o` all 0.
- Cycle numbering: cycle 0 is the edge at which `start_i` is sampled in IDLE.
- Normal divide: DIV_ON in cycles 1..32, WR_LO in cycle 33, WR_HI in cycle 34, IDLE in cycle 35.
- Divide by zero: DIV_ZERO in cycle 1, WR_LO in cycle 2, WR_HI in cycle 3.
- `busy_o`:
  - Combinational: `(state != IDLE && state != WR_HI) || (state == IDLE && start_i && !annul_i)`.
  - It is high in the request cycle itself.
  - It drops in WR_HI, so the stalled instruction advances during the same cycle as the HI write.
- `done_o` equals `state == WR_HI`.
- Write outputs are driven from registered state. A HI/LO reader sees each value in its write cycle through the register file's write bypass.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, partial results discarded and no writes.

## Structure
- Shared defines:
  - Divider state encodings: DIV_IDLE, DIV_ZERO, DIV_ON, DIV_WR_LO, DIV_WR_HI.
  - Address constants: HILO_ADDR_LO = 1'b0 and HILO_ADDR_HI = 1'b1.
  - Existing RegBus, RegWidth, WriteEnable and WriteDisable.
- Sub-modules: none. The iterative datapath and the sign correction are inline; a sub-module would add ports without adding reuse.

## Test plan
- Unsigned 100 / 7: LO write `0x0000000E` in cycle 33, HI write `0x00000002` in cycle 34, `done_o` in cycle 34, `busy_o` low from cycle 34.
- Signed `0xFFFFFFF9` (−7) / 2: LO = `0xFFFFFFFD`, HI = `0xFFFFFFFF`. Unsigned mode on the same operands: LO = `0x7FFFFFFC`, HI = 1.
- Signed `0x80000000` / `0xFFFFFFFF`: LO = `0x80000000`, HI = 0, with no error indication.
- Divisor 0 with dividend `0x12345678`: LO = 0 in cycle 2, HI = 0 in cycle 3, and only those two writes occur.
- `annul_i` pulsed in cycle 10: no `hilo_w_en_o` at any time, IDLE in cycle 11, and a new start in cycle 12 completes normally.
- `rst_n` dropped in cycle 20 and released: all outputs 0 at once, no write; `start_i` held during the DIV_ON cycles of a following divide is ignored.
